mem_stage: RTL
==============

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the EX/MEM boundary of the RISC-V pipeline.
- Consumes the EX results: aluop, effective address, store data, and register-write info.
- Performs loads and stores over a shared byte-wide RAM port, one byte per granted cycle.
- Drives the registered MEM/WB outputs and raises a stall request to STALLER while an access is in flight.

Parameters:
AW, 17, width of mem_addr_o; the effective address is truncated to AW bits, and byte addresses wrap modulo 2^AW.
STALL_CODE, 2'b10, value driven on rq_STALLER_o while this stage is stalling; 2'b00 means no request.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
aluop_EXMEM_i  in  `AluOpBus  operation from EX
wreg_EXMEM_i  in  1  register-write enable
waddr_EXMEM_i  in  5  destination register
alurslt_EXMEM_i  in  32  ALU result or effective address
SdataBoffset_EXMEM_i  in  32  store data
mem_gnt_i  in  1  arbiter grants this cycle's memory request
mem_rdata_i  in  8  read byte, valid the cycle after a granted read
mem_addr_o  out  AW  byte address
mem_wdata_o  out  8  write byte
mem_we_o  out  1  write request
mem_re_o  out  1  read request
wreg_MEMWB_o  out  1  registered
waddr_MEMWB_o  out  5  registered
wdata_MEMWB_o  out  32  registered write-back data
rq_STALLER_o  out  2  combinational stall request

Behaviour:
- Memory ops: `ALU_LB/LH/LW/LBU/LHU_OP` (loads) and `ALU_SB/SH/SW_OP` (stores).
- Byte count N: 1 for B/BU, 2 for H/HU, 4 for W.
- Every other aluop, including unknown codes, is a non-memory op.
- While rq_STALLER_o != 0, STALLER holds the EX/MEM inputs stable.
- Reset (rst=0), taking effect immediately:
  - state=IDLE, cnt=0, rd_pending=0, buf=0.
  - All MEM/WB outputs 0; rq_STALLER_o=0; mem_we_o=mem_re_o=0; mem_addr_o=0; mem_wdata_o=0.
  - Reset mid-access abandons the operation; bytes already written stay written.
- State IDLE:
  - Non-memory op: rq=0.
  - Memory op: rq=STALL_CODE, go to XFER with cnt=0. No memory request is issued in IDLE.
- State XFER:
  - rq=STALL_CODE.
  - mem_addr_o = alurslt[AW-1:0] + cnt.
  - Store: mem_we_o=1, mem_wdata_o = SdataBoffset[8*cnt+7 : 8*cnt].
  - Load: mem_re_o=1.
  - If mem_gnt_i=1:
    - Load: rd_pending<=1, rd_idx<=cnt.
    - If cnt==N-1: store goes to DONE, load goes to WAIT; otherwise cnt++.
  - If mem_gnt_i=0: cnt, address and data are held and the request is repeated; rd_pending<=0.
- Read capture: in any state, if rd_pending=1 then buf[8*rd_idx +: 8] <= mem_rdata_i.
- State WAIT:
  - rq=STALL_CODE, no memory request.
  - The last byte is captured, then go to DONE.
- State DONE:
  - rq=0, no memory request.
  - The MEM/WB registers load the result; next state IDLE.
  - DONE never restarts the same instruction.
- MEM/WB registers, at each rising edge:
  - If rq_STALLER_o=0: wreg/waddr take the inputs; wdata = alurslt for non-memory ops and stores, extended buf for loads.
  - Otherwise a bubble is loaded: wreg=0, waddr=0, wdata=0.
- Load extension:
  - LB: sign-extend buf[7:0]. LBU: zero-extend buf[7:0].
  - LH: sign-extend buf[15:0]. LHU: zero-extend buf[15:0].
  - LW: buf unchanged.
- Byte order and alignment: little-endian, no alignment check; accesses may cross word boundaries.
- Latency with continuous grant:
  - Non-memory op: 1 cycle, 0 stall cycles.
  - LW: rq high 6 cycles (IDLE, 4xXFER, WAIT).
  - SW: rq high 5 cycles.
  - Each cycle mem_gnt_i=0 in XFER adds one stall cycle.

Test Plan:
1. ADD, alurslt=0x00001234, wreg=1, waddr=5 -> after 1 edge wdata=0x00001234, waddr=5, wreg=1; rq=0 throughout; no mem_re/we.
2. LW @0x100, RAM bytes 11,22,33,44, gnt=1 -> mem_addr_o 0x100..0x103 on 4 consecutive cycles; rq high 6 cycles; then wdata=0x44332211.
3. RAM[0x80]=0x80, RAM[0x81]=0x80 (RAM[0x80..0x81]=0x8080) -> LB@0x80 gives 0xFFFFFF80; LBU gives 0x00000080; LH gives 0xFFFF8080; LHU gives 0x00008080.
4. SH @0x201, data 0xDEADBEEF -> writes 0xEF@0x201 and 0xBE@0x202, no write to 0x203; rq high 3 cycles; MEM/WB wreg=0.
5. LW with gnt=0 for 3 cycles during byte 1 -> addr 0x101 held 3 cycles; rq high 9 cycles total; result still 0x44332211.
6. rst driven 0 during XFER of a LW -> outputs/rq zero immediately; after release, the next ADD passes through with 1-cycle latency.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage: byte-serial loads/stores over a shared 8-bit RAM port, registered MEM/WB outputs
// and a stall request held for the whole access.
`ifndef AluOpBus
`define AluOpBus 7:0
`endif
`ifndef ALU_LB_OP
`define ALU_LB_OP  8'h01
`define ALU_LH_OP  8'h02
`define ALU_LW_OP  8'h03
`define ALU_LBU_OP 8'h04
`define ALU_LHU_OP 8'h05
`define ALU_SB_OP  8'h06
`define ALU_SH_OP  8'h07
`define ALU_SW_OP  8'h08
`define ALU_ADD_OP 8'h10
`endif

module mem_byte_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] q
);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    q <= 8'h00;
    else if (en) q <= d;
  end
endmodule

module mem_stage #(
  parameter int          AW         = 17,
  parameter logic [1:0]  STALL_CODE = 2'b10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [`AluOpBus]  aluop_EXMEM_i,
  input  logic              wreg_EXMEM_i,
  input  logic [4:0]        waddr_EXMEM_i,
  input  logic [31:0]       alurslt_EXMEM_i,
  input  logic [31:0]       SdataBoffset_EXMEM_i,
  input  logic              mem_gnt_i,
  input  logic [7:0]        mem_rdata_i,
  output logic [AW-1:0]     mem_addr_o,
  output logic [7:0]        mem_wdata_o,
  output logic              mem_we_o,
  output logic              mem_re_o,
  output logic              wreg_MEMWB_o,
  output logic [4:0]        waddr_MEMWB_o,
  output logic [31:0]       wdata_MEMWB_o,
  output logic [1:0]        rq_STALLER_o
);
  typedef enum logic [1:0] {IDLE, XFER, WAIT, DONE} state_t;

  state_t          state, state_nx;
  logic [1:0]      cnt, cnt_nx, rd_idx, rd_idx_nx, last;
  logic            rd_pending, rd_pending_nx;
  logic            is_load, is_store, stall;
  logic [3:0][7:0] rbuf;
  logic [31:0]     ld_data;

  // last holds N-1 so the byte counter never needs more than 2 bits
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    last     = 2'd0;
    case (aluop_EXMEM_i)
      `ALU_LB_OP, `ALU_LBU_OP: is_load = 1'b1;
      `ALU_LH_OP, `ALU_LHU_OP: begin is_load = 1'b1; last = 2'd1; end
      `ALU_LW_OP:              begin is_load = 1'b1; last = 2'd3; end
      `ALU_SB_OP:              is_store = 1'b1;
      `ALU_SH_OP:              begin is_store = 1'b1; last = 2'd1; end
      `ALU_SW_OP:              begin is_store = 1'b1; last = 2'd3; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 2'd0;
      rd_pending <= 1'b0;
      rd_idx     <= 2'd0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      rd_pending <= rd_pending_nx;
      rd_idx     <= rd_idx_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    cnt_nx        = cnt;
    rd_pending_nx = 1'b0;
    rd_idx_nx     = rd_idx;
    stall         = 1'b0;
    mem_we_o      = 1'b0;
    mem_re_o      = 1'b0;
    mem_addr_o    = '0;
    mem_wdata_o   = 8'h00;
    case (state)
      IDLE: if (is_load || is_store) begin
        stall    = 1'b1;
        state_nx = XFER;
        cnt_nx   = 2'd0;
      end
      XFER: begin
        stall      = 1'b1;
        mem_addr_o = alurslt_EXMEM_i[AW-1:0] + {{(AW-2){1'b0}}, cnt};
        if (is_store) begin
          mem_we_o    = 1'b1;
          mem_wdata_o = SdataBoffset_EXMEM_i[{cnt, 3'b000} +: 8];
        end else begin
          mem_re_o    = is_load;
        end
        if (!is_load && !is_store) begin
          state_nx = IDLE;
        end else if (mem_gnt_i) begin
          rd_pending_nx = is_load;
          rd_idx_nx     = cnt;
          if (cnt == last) begin
            state_nx = is_load ? WAIT : DONE;
            cnt_nx   = 2'd0;
          end else begin
            cnt_nx   = cnt + 2'd1;
          end
        end
      end
      WAIT: begin
        stall    = 1'b1;
        state_nx = DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // reset must silence the request even though IDLE would stall on a pending memory op
  assign rq_STALLER_o = (stall && rst) ? STALL_CODE : 2'b00;

  for (genvar g = 0; g < 4; g++) begin : g_lane
    mem_byte_lane u_lane (
      .clk (clk),
      .rst (rst),
      .en  (rd_pending && (rd_idx == 2'(g))),
      .d   (mem_rdata_i),
      .q   (rbuf[g])
    );
  end

  always_comb begin
    case (aluop_EXMEM_i)
      `ALU_LB_OP:  ld_data = {{24{rbuf[0][7]}}, rbuf[0]};
      `ALU_LBU_OP: ld_data = {24'h0, rbuf[0]};
      `ALU_LH_OP:  ld_data = {{16{rbuf[1][7]}}, rbuf[1], rbuf[0]};
      `ALU_LHU_OP: ld_data = {16'h0, rbuf[1], rbuf[0]};
      default:     ld_data = rbuf;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wreg_MEMWB_o  <= 1'b0;
      waddr_MEMWB_o <= 5'd0;
      wdata_MEMWB_o <= 32'h0;
    end else if (!stall) begin
      wreg_MEMWB_o  <= wreg_EXMEM_i;
      waddr_MEMWB_o <= waddr_EXMEM_i;
      wdata_MEMWB_o <= is_load ? ld_data : alurslt_EXMEM_i;
    end else begin
      wreg_MEMWB_o  <= 1'b0;
      waddr_MEMWB_o <= 5'd0;
      wdata_MEMWB_o <= 32'h0;
    end
  end
endmodule
